rf_text_screen_ram_engine: RTL and testbench
============================================

// Module: rf_text_screen_ram_engine
// PURPOSE
// Parametrised text-screen cell RAM for the text controller. Width, depth and latencies are configurable.
// Port A is a host bus port with a req/ack handshake. Port B is a read-only, non-stalling video fetch port.
// A built-in engine does block fill (clear screen) and overlap-safe block copy (scroll) on port A,
// one cell per clock. Memory is inferred, with no vendor macro; single clock domain.
// PARAMETERS
// WID        64     cell width in bits, 32 or 64; byte lanes = WID/8
// CELLS      49152  number of cells; AWID = $clog2(CELLS); need not be a power of two
// HOST_LAT   2      host accept-to-ack cycles, 1..3
// VID_LAT    1      video address-to-data cycles, 1..2
// PORTS
// clk_i       in   1        clock
// rstn_i      in   1        asynchronous active-low reset
// cs_i        in   1        host request; hold until ack_o
// we_i        in   1        host write
// sel_i       in   WID/8    host byte selects
// adr_i       in   AWID     host cell index
// dat_i       in   WID      host write data
// dat_o       out  WID      host read data, valid with ack_o
// ack_o       out  1        one-cycle acknowledge
// vid_adr_i   in   AWID     video cell index, sampled every cycle
// vid_dat_o   out  WID      video read data
// cmd_i       in   1        0 = fill, 1 = copy; sampled with start_i
// start_i     in   1        start engine; honoured only in IDLE
// abort_i     in   1        abort running engine operation
// src_i       in   AWID     copy source base
// dst_i       in   AWID     fill/copy destination base
// cnt_i       in   AWID+1   cell count
// fill_i      in   WID      fill value
// busy_o      out  1        engine owns port A
// done_o      out  1        one-cycle completion pulse, including abort and count 0
// BEHAVIOUR
// Reset values
// - On reset, ack_o, busy_o and done_o go to 0, and dat_o and vid_dat_o go to 0.
// - On reset, the FSM goes to IDLE and all pipelines are flushed.
// - RAM contents are not reset.
// Host port
// - The host is accepted on an edge where cs_i=1, the FSM is IDLE and start_i=0.
// - A write commits at the accept edge, masked by sel_i.
// - ack_o pulses HOST_LAT cycles after accept; read data is registered into dat_o on that same edge.
// - dat_o holds its value between acks.
// - A new accept is not allowed until the previous ack has been issued, so at most one access is in flight.
// - If adr_i >= CELLS: the write is dropped, a read returns 0, and ack_o is still issued.
// - While busy_o=1 the host is not accepted and ack_o stays 0; the host keeps cs_i asserted.
// Video port
// - vid_dat_o = mem[vid_adr_i] VID_LAT cycles later, every cycle, with no stall.
// - Engine and host writes do not affect video timing.
// - Same-cycle write and video read of one cell returns the old data.
// - If vid_adr_i >= CELLS, vid_dat_o = 0.
// Engine state machine: IDLE, FILL, CPRIME, COPY, DONE
// - IDLE with start_i=1:
//   - if cnt_i=0, go to DONE;
//   - if cmd_i=0, go to FILL;
//   - otherwise go to CPRIME.
// - start_i wins over a same-cycle cs_i.
// - If start_i is asserted while a host access is in flight, the FSM waits in IDLE until ack_o, then starts.
// - busy_o=1 in FILL, CPRIME and COPY.
// - FILL: writes fill_i to cell dst+k, k=0..cnt-1, one per cycle, all lanes. After cnt cycles, go to DONE.
// - CPRIME: issues the first source read. The internal read latency is 1.
// - COPY: writes the previous cycle's read data to the destination and reads the next source cell.
// - A copy takes cnt+1 cycles in total, then goes to DONE.
// - Copy direction is chosen at start:
//   - ascending if dst_i <= src_i;
//   - descending otherwise, starting at base+cnt-1, so overlapping regions copy correctly.
// - Addresses wrap modulo CELLS in both directions; the wrap is an explicit compare, not a power-of-two mask.
// - DONE lasts one cycle: done_o=1, busy_o=0, then the FSM returns to IDLE.
// - abort_i=1 in FILL, CPRIME or COPY stops writes from that edge onward, and the FSM goes to DONE.
//   The partially written range stays as written.
// - A reset mid-operation stops the engine immediately. No further writes occur and no done_o is issued.
// TESTING
// - Host path, WID=64, HOST_LAT=2:
//   - write 0x1122334455667788 to cell 5 with sel=8'h0F, then read cell 5 -> ack 2 cycles after accept,
//     dat_o = 0x0000000055667788.
// - Fill: dst=100, cnt=80, fill=0x20 -> busy_o high for 80 cycles, then done_o.
//   Cells 100..179 = 0x20, cells 99 and 180 unchanged.
// - Overlapping copy:
//   - ascending, src=80, dst=0, cnt=160 -> cells 0..159 equal the original cells 80..239;
//   - descending, src=0, dst=80, cnt=160 -> cells 80..239 equal the original cells 0..159;
//   - each copy takes 161 busy cycles.
// - Wrap, CELLS=49152: fill dst=49150, cnt=4 -> cells 49150, 49151, 0 and 1 are written.
//   adr_i=49152: write is dropped, read returns 0, ack_o still issued.
// - Contention:
//   - cs_i held during a fill -> ack_o arrives HOST_LAT cycles after the cycle following done_o;
//   - abort_i on the 10th FILL cycle -> exactly 9 cells written, then done_o.
// - Reset: rstn_i low mid-copy -> busy_o, ack_o and done_o are 0 the same cycle; memory retained;
//   video reads of untouched cells return their prior values.

Source files
------------

// File: rtl/rf_text_screen_ram_engine.sv
// Text-screen cell RAM: host req/ack port A, non-stalling video read port B, and a
// one-cell-per-clock fill/copy engine that owns port A while busy.
module rf_text_screen_ram_engine #(
  parameter int unsigned  WID      = 64,
  parameter int unsigned  CELLS    = 49152,
  parameter int unsigned  HOST_LAT = 2,
  parameter int unsigned  VID_LAT  = 1,
  localparam int unsigned AWID     = $clog2(CELLS),
  localparam int unsigned NB       = WID / 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            cs_i,
  input  logic            we_i,
  input  logic [NB-1:0]   sel_i,
  input  logic [AWID-1:0] adr_i,
  input  logic [WID-1:0]  dat_i,
  output logic [WID-1:0]  dat_o,
  output logic            ack_o,
  input  logic [AWID-1:0] vid_adr_i,
  output logic [WID-1:0]  vid_dat_o,
  input  logic            cmd_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [AWID-1:0] src_i,
  input  logic [AWID-1:0] dst_i,
  input  logic [AWID:0]   cnt_i,
  input  logic [WID-1:0]  fill_i,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [2:0] {StIdle, StFill, StCprime, StCopy, StDone} state_e;

  localparam logic [AWID:0]   CELLS_LIM = (AWID + 1)'(CELLS);
  localparam logic [AWID-1:0] LAST_CELL = AWID'(CELLS - 1);
  localparam logic [AWID:0]   CNT_ONE   = (AWID + 1)'(1);

  logic [WID-1:0] mem [CELLS];

  state_e          state_q;
  logic [AWID-1:0] wptr_q, rptr_q;
  logic [AWID:0]   rem_q;
  logic            asc_q;
  logic [WID-1:0]  fill_q, cdat_q;

  logic            inflight_q;
  logic [1:0]      lat_q;
  logic [WID-1:0]  hrd_q;
  logic            accept;

  logic            wr_en;
  logic [AWID-1:0] wr_addr;
  logic [WID-1:0]  wr_data;
  logic [NB-1:0]   wr_be;

  logic [WID-1:0]  vpipe_q [VID_LAT];

  function automatic logic in_range(input logic [AWID-1:0] a);
    return {1'b0, a} < CELLS_LIM;
  endfunction

  // Wrap is an explicit compare so non-power-of-two depths work.
  function automatic logic [AWID-1:0] inc_wrap(input logic [AWID-1:0] a);
    return (a == LAST_CELL) ? '0 : a + AWID'(1);
  endfunction

  function automatic logic [AWID-1:0] dec_wrap(input logic [AWID-1:0] a);
    return (a == '0) ? LAST_CELL : a - AWID'(1);
  endfunction

  function automatic logic [AWID-1:0] end_addr(input logic [AWID-1:0] base,
                                               input logic [AWID:0]   cnt);
    logic [AWID+1:0] s;
    s = {2'b00, base} + {1'b0, cnt} - (AWID + 2)'(1);
    if (s >= {1'b0, CELLS_LIM}) s = s - {1'b0, CELLS_LIM};
    return s[AWID-1:0];
  endfunction

  // ack_o high blocks a re-accept while the host still holds cs_i in its ack cycle.
  assign accept = rstn_i && cs_i && (state_q == StIdle) && !start_i && !inflight_q && !ack_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflight_q <= 1'b0;
      lat_q      <= '0;
      hrd_q      <= '0;
      ack_o      <= 1'b0;
      dat_o      <= '0;
    end else begin
      ack_o <= 1'b0;
      if (accept) begin
        inflight_q <= 1'b1;
        lat_q      <= 2'(HOST_LAT);
        hrd_q      <= in_range(adr_i) ? mem[adr_i] : '0;
      end else if (inflight_q) begin
        lat_q <= lat_q - 2'd1;
        if (lat_q == 2'd1) begin
          inflight_q <= 1'b0;
          ack_o      <= 1'b1;
          dat_o      <= hrd_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rem_q   <= '0;
      asc_q   <= 1'b1;
      fill_q  <= '0;
      cdat_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          done_o <= 1'b0;
          if (start_i && !inflight_q) begin
            fill_q <= fill_i;
            rem_q  <= cnt_i;
            asc_q  <= (dst_i <= src_i);
            if (cnt_i == '0) begin
              state_q <= StDone;
              done_o  <= 1'b1;
            end else if (!cmd_i) begin
              state_q <= StFill;
              busy_o  <= 1'b1;
              wptr_q  <= dst_i;
            end else begin
              state_q <= StCprime;
              busy_o  <= 1'b1;
              wptr_q  <= (dst_i <= src_i) ? dst_i : end_addr(dst_i, cnt_i);
              rptr_q  <= (dst_i <= src_i) ? src_i : end_addr(src_i, cnt_i);
            end
          end
        end
        StFill: begin
          if (abort_i || rem_q == CNT_ONE) begin
            state_q <= StDone;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            wptr_q <= inc_wrap(wptr_q);
            rem_q  <= rem_q - CNT_ONE;
          end
        end
        StCprime: begin
          if (abort_i) begin
            state_q <= StDone;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            state_q <= StCopy;
            cdat_q  <= in_range(rptr_q) ? mem[rptr_q] : '0;
            rptr_q  <= asc_q ? inc_wrap(rptr_q) : dec_wrap(rptr_q);
          end
        end
        StCopy: begin
          if (abort_i || rem_q == CNT_ONE) begin
            state_q <= StDone;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            cdat_q <= in_range(rptr_q) ? mem[rptr_q] : '0;
            rptr_q <= asc_q ? inc_wrap(rptr_q) : dec_wrap(rptr_q);
            wptr_q <= asc_q ? inc_wrap(wptr_q) : dec_wrap(wptr_q);
            rem_q  <= rem_q - CNT_ONE;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_o  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

  // Single write port: host accepts only in IDLE, so it never collides with the engine.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = adr_i;
    wr_data = dat_i;
    wr_be   = sel_i;
    if (accept && we_i) wr_en = in_range(adr_i);
    case (state_q)
      StFill: begin
        wr_en   = !abort_i && in_range(wptr_q);
        wr_addr = wptr_q;
        wr_data = fill_q;
        wr_be   = '1;
      end
      StCopy: begin
        wr_en   = !abort_i && in_range(wptr_q);
        wr_addr = wptr_q;
        wr_data = cdat_q;
        wr_be   = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < VID_LAT; i++) vpipe_q[i] <= '0;
    end else begin
      vpipe_q[0] <= in_range(vid_adr_i) ? mem[vid_adr_i] : '0;
      for (int i = 1; i < VID_LAT; i++) vpipe_q[i] <= vpipe_q[i-1];
    end
  end

  assign vid_dat_o = vpipe_q[VID_LAT-1];

endmodule

// File: tb/tb_rf_text_screen_ram_engine.sv
// Directed bench for rf_text_screen_ram_engine: host port, video port, fill/copy engine,
// wrap, out-of-range access, contention, abort and mid-operation reset.
module tb_rf_text_screen_ram_engine;

  localparam int WID      = 64;
  localparam int CELLS    = 49152;
  localparam int HOST_LAT = 2;
  localparam int VID_LAT  = 1;
  localparam int AWID     = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic            cs, we, ack, cmd, start, abort, busy, done;
  logic [7:0]      sel;
  logic [AWID-1:0] adr, vid_adr, src, dst;
  logic [AWID:0]   cnt;
  logic [63:0]     wdat, rdat, vdat, fill;

  int total = 0;
  int bad   = 0;

  logic [63:0] model [256];
  logic [63:0] snap  [256];
  logic [63:0] rd, d, old;
  int          lat, bc, n, nd, na, early_ack, saw;

  always #5 clk = ~clk;

  rf_text_screen_ram_engine #(
    .WID      (WID),
    .CELLS    (CELLS),
    .HOST_LAT (HOST_LAT),
    .VID_LAT  (VID_LAT)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .cs_i      (cs),
    .we_i      (we),
    .sel_i     (sel),
    .adr_i     (adr),
    .dat_i     (wdat),
    .dat_o     (rdat),
    .ack_o     (ack),
    .vid_adr_i (vid_adr),
    .vid_dat_o (vdat),
    .cmd_i     (cmd),
    .start_i   (start),
    .abort_i   (abort),
    .src_i     (src),
    .dst_i     (dst),
    .cnt_i     (cnt),
    .fill_i    (fill),
    .busy_o    (busy),
    .done_o    (done)
  );

  function automatic logic [63:0] pat(input int i);
    return {16'hC0DE, 16'(i), 16'(i * 7 + 3), 16'hBEEF ^ 16'(i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Idles one cycle so a previous ack has cleared, then holds cs until ack.
  task automatic host_access(input logic w, input logic [AWID-1:0] a, input logic [63:0] wd,
                             input logic [7:0] s, output logic [63:0] r, output int l);
    int  k;
    logic got;
    @(posedge clk); #1;
    cs = 1'b1; we = w; adr = a; wdat = wd; sel = s;
    k = 0; got = 1'b0;
    while (!got && k < 50) begin
      @(posedge clk); #1;
      k++;
      if (ack) got = 1'b1;
    end
    check("host_ack_seen", 64'(got), 64'(1));
    l = k - 1;
    r = rdat;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic vid_read(input logic [AWID-1:0] a, output logic [63:0] v);
    vid_adr = a;
    @(posedge clk); #1;
    v = vdat;
  endtask

  task automatic vid_check(input int lo, input int hi);
    logic [63:0] v;
    for (int a = lo; a <= hi; a++) begin
      vid_read(16'(a), v);
      check($sformatf("cell%0d", a), v, model[a]);
    end
  endtask

  task automatic run_engine(input logic c, input logic [AWID-1:0] s, input logic [AWID-1:0] ds,
                            input logic [AWID:0] ct, input logic [63:0] f,
                            output int bcyc, output logic [63:0] v1);
    cmd = c; src = s; dst = ds; cnt = ct; fill = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcyc = 0; v1 = '0;
    while (busy && bcyc < 2000) begin
      bcyc++;
      @(posedge clk); #1;
      if (bcyc == 1) v1 = vdat;
    end
    check("done_pulse", 64'(done), 64'(1));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cs = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0; vid_adr = '0;
    cmd = 1'b0; start = 1'b0; abort = 1'b0; src = '0; dst = '0; cnt = '0; fill = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dat", rdat, 64'(0));
    check("rst_vid", vdat, 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) begin
      model[i] = pat(i);
      host_access(1'b1, 16'(i), pat(i), 8'hFF, rd, lat);
    end
    vid_read(16'd7, d);
    check("init_vid7", d, pat(7));
    host_access(1'b0, 16'd200, '0, '0, rd, lat);
    check("init_host200", rd, pat(200));
    check("read_lat", 64'(lat), 64'(HOST_LAT));

    // Byte-masked write over a zeroed cell.
    host_access(1'b1, 16'd5, '0, 8'hFF, rd, lat);
    host_access(1'b1, 16'd5, 64'h1122334455667788, 8'h0F, rd, lat);
    check("write_lat", 64'(lat), 64'(HOST_LAT));
    host_access(1'b0, 16'd5, '0, '0, rd, lat);
    check("masked_read", rd, 64'h0000000055667788);
    check("masked_read_lat", 64'(lat), 64'(HOST_LAT));
    @(posedge clk); #1;
    check("ack_one_cycle", 64'(ack), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    check("dat_hold", rdat, 64'h0000000055667788);
    model[5] = 64'h0000000055667788;

    snap = model;
    for (int i = 0; i < 160; i++) model[i] = snap[80 + i];
    run_engine(1'b1, 16'd80, 16'd0, 17'd160, '0, bc, d);
    check("asc_copy_busy", 64'(bc), 64'(161));
    vid_check(0, 255);

    snap = model;
    for (int i = 0; i < 160; i++) model[80 + i] = snap[i];
    run_engine(1'b1, 16'd0, 16'd80, 17'd160, '0, bc, d);
    check("desc_copy_busy", 64'(bc), 64'(161));
    vid_check(0, 255);

    // Video reads cell 100 on the same edge the fill first writes it.
    vid_adr = 16'd100;
    old = model[100];
    run_engine(1'b0, 16'd0, 16'd100, 17'd80, 64'h20, bc, d);
    check("fill_busy", 64'(bc), 64'(80));
    check("vid_old_on_write", d, old);
    for (int i = 100; i < 180; i++) model[i] = 64'h20;
    vid_check(99, 180);

    run_engine(1'b0, 16'd0, 16'd50, 17'd0, 64'hFFFF, bc, d);
    check("zero_cnt_busy", 64'(bc), 64'(0));
    vid_check(50, 50);

    host_access(1'b1, 16'd49149, 64'h1234, 8'hFF, rd, lat);
    run_engine(1'b0, 16'd0, 16'd49150, 17'd4, 64'hDEAD, bc, d);
    check("wrap_busy", 64'(bc), 64'(4));
    vid_read(16'd49149, d); check("wrap_49149", d, 64'h1234);
    vid_read(16'd49150, d); check("wrap_49150", d, 64'hDEAD);
    vid_read(16'd49151, d); check("wrap_49151", d, 64'hDEAD);
    model[0] = 64'hDEAD;
    model[1] = 64'hDEAD;
    vid_check(0, 2);

    host_access(1'b0, 16'd7, '0, '0, rd, lat);
    check("pre_oob_read", rd, model[7]);
    host_access(1'b1, 16'd49152, 64'hBEEF_BEEF_BEEF_BEEF, 8'hFF, rd, lat);
    check("oob_write_lat", 64'(lat), 64'(HOST_LAT));
    host_access(1'b0, 16'd49152, '0, '0, rd, lat);
    check("oob_read_zero", rd, 64'(0));
    check("oob_read_lat", 64'(lat), 64'(HOST_LAT));
    vid_read(16'd49152, d); check("oob_vid_zero", d, 64'(0));
    vid_read(16'd49151, d); check("oob_no_corrupt", d, 64'hDEAD);

    // Host holds cs across a fill; start must win on the shared first edge.
    cmd = 1'b0; dst = 16'd200; cnt = 17'd20; fill = 64'h77; start = 1'b1;
    cs = 1'b1; we = 1'b0; adr = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; nd = -1; na = -1; early_ack = 0; rd = '0;
    while (na < 0 && n < 200) begin
      if (done && nd < 0) nd = n;
      if (ack) begin
        na = n;
        rd = rdat;
        if (nd < 0) early_ack = 1;
      end
      if (na < 0) begin
        @(posedge clk); #1;
        n++;
      end
    end
    cs = 1'b0;
    check("cont_no_early_ack", 64'(early_ack), 64'(0));
    check("cont_done_at", 64'(nd), 64'(20));
    // Accept on the edge ending the first IDLE cycle after done, ack HOST_LAT edges later.
    check("cont_ack_delay", 64'(na - nd), 64'(2 + HOST_LAT));
    check("cont_read_data", rd, 64'h20);
    for (int i = 200; i < 220; i++) model[i] = 64'h77;
    vid_check(199, 220);

    cmd = 1'b0; dst = 16'd10; cnt = 17'd50; fill = 64'hAB; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_done", 64'(done), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    check("abort_done_clear", 64'(done), 64'(0));
    for (int i = 10; i < 19; i++) model[i] = 64'hAB;
    vid_check(8, 20);

    // Descending copy writes from cell 227 downward; reset lands after ~19 writes.
    cmd = 1'b1; src = 16'd0; dst = 16'd128; cnt = 17'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_copy_busy", 64'(busy), 64'(1));
    rstn = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_ack", 64'(ack), 64'(0));
    check("rst_mid_vid", vdat, 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    saw = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1;
    end
    check("no_done_after_reset", 64'(saw), 64'(0));
    vid_check(0, 200);
    vid_check(228, 255);
    host_access(1'b0, 16'd50, '0, '0, rd, lat);
    check("post_reset_host", rd, model[50]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
